// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: skid-buffer state encoding
// and the ME->WB payload layout used when packing/unpacking at the boundary.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

  localparam int MEWB_W   = 71;
  localparam int RMEM_BIT = 0;
  localparam int WREG_BIT = 1;
  localparam int RW_LSB   = 2;
  localparam int MO_LSB   = 7;
  localparam int ANS_LSB  = 39;

  // Field order matches the offsets above (ans in the MSBs, rmem in bit 0).
  typedef struct packed {
    logic [31:0] ans;
    logic [31:0] mo;
    logic [4:0]  rw;
    logic        wreg;
    logic        rmem;
  } mewb_t;

  function automatic logic [MEWB_W-1:0] pack_mewb(
    input logic [31:0] ans,
    input logic [31:0] mo,
    input logic [4:0]  rw,
    input logic        wreg,
    input logic        rmem
  );
    mewb_t w_b;
    w_b.ans  = ans;
    w_b.mo   = mo;
    w_b.rw   = rw;
    w_b.wreg = wreg;
    w_b.rmem = rmem;
    return w_b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; shared by the
// per-stage performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_0,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Count register: clears on reset, sticks at all-ones.
  always_ff @(posedge clock) begin
    if (!reset_0) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign count = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage register with a two-entry skid buffer, synchronous
// flush and a saturating back-pressure counter; every output is a flop.
import pipe_pkg::*;

module pipe_skid_reg #(
  parameter int PAYLOAD_W = 71,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset_0,
  input  logic                 flush,
  input  logic                 up_valid,
  input  logic [PAYLOAD_W-1:0] up_data,
  output logic                 up_ready,
  output logic                 dn_valid,
  output logic [PAYLOAD_W-1:0] dn_data,
  input  logic                 dn_ready,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [PAYLOAD_W-1:0] ZERO_P = {PAYLOAD_W{1'b0}};

  skid_state_e          r_state;
  logic [PAYLOAD_W-1:0] r_m;
  logic [PAYLOAD_W-1:0] r_s;
  logic                 r_dn_valid;
  logic                 r_up_ready;

  skid_state_e          w_state_nx;
  logic [PAYLOAD_W-1:0] w_m_nx;
  logic [PAYLOAD_W-1:0] w_s_nx;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_stall;

  assign w_accept = up_valid & r_up_ready;
  assign w_pop    = r_dn_valid & dn_ready;
  assign w_stall  = r_dn_valid & ~dn_ready;

  // Next-state and next-datapath selection; flush overrides every transition.
  always_comb begin
    w_state_nx = r_state;
    w_m_nx     = r_m;
    w_s_nx     = r_s;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_m_nx     = up_data;
          w_state_nx = ST_ONE;
        end else begin
          w_state_nx = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          w_m_nx     = up_data;
          w_state_nx = ST_ONE;
        end else if (w_accept) begin
          w_s_nx     = up_data;
          w_state_nx = ST_FULL;
        end else if (w_pop) begin
          w_state_nx = ST_EMPTY;
        end else begin
          w_state_nx = ST_ONE;
        end
      end
      ST_FULL: begin
        // up_ready is low here, so only a pop can move the state.
        if (w_pop) begin
          w_m_nx     = r_s;
          w_state_nx = ST_ONE;
        end else begin
          w_state_nx = ST_FULL;
        end
      end
      default: begin
        w_state_nx = ST_EMPTY;
        w_m_nx     = ZERO_P;
        w_s_nx     = ZERO_P;
      end
    endcase
    if (flush) begin
      w_state_nx = ST_EMPTY;
      w_m_nx     = ZERO_P;
      w_s_nx     = ZERO_P;
    end else begin
      w_state_nx = w_state_nx;
    end
  end

  // State/data registers; handshake flags are decoded from the next state so
  // that up_ready and dn_valid come straight out of flops.
  always_ff @(posedge clock) begin
    if (!reset_0) begin
      r_state    <= ST_EMPTY;
      r_m        <= ZERO_P;
      r_s        <= ZERO_P;
      r_dn_valid <= 1'b0;
      r_up_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_m        <= w_m_nx;
      r_s        <= w_s_nx;
      r_dn_valid <= (w_state_nx != ST_EMPTY);
      r_up_ready <= (w_state_nx != ST_FULL);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_0 (reset_0),
    .inc     (w_stall),
    .count   (stall_cnt)
  );

  assign up_ready = r_up_ready;
  assign dn_valid = r_dn_valid;
  assign dn_data  = r_m;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: scenario tasks compared each cycle against a
// two-deep FIFO reference model; a second instance uses a 4-bit stall counter.
module tb_pipe_skid_reg;

  localparam int PW  = 71;
  localparam int CW  = 16;
  localparam int CW4 = 4;

  logic          clock = 1'b0;
  logic          reset_0;
  logic          flush;
  logic          up_valid;
  logic [PW-1:0] up_data;
  logic          dn_ready;

  logic          up_ready, dn_valid;
  logic [PW-1:0] dn_data;
  logic [CW-1:0] stall_cnt;
  logic          up_ready4, dn_valid4;
  logic [PW-1:0] dn_data4;
  logic [CW4-1:0] stall_cnt4;

  logic [PW-1:0] q[$];
  logic [PW-1:0] md;
  int            mc16;
  int            mc4;
  int            n_checks = 0;
  int            n_errors = 0;

  pipe_skid_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clock(clock), .reset_0(reset_0), .flush(flush), .up_valid(up_valid),
    .up_data(up_data), .up_ready(up_ready), .dn_valid(dn_valid),
    .dn_data(dn_data), .dn_ready(dn_ready), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.PAYLOAD_W(PW), .CNT_W(CW4)) dut4 (
    .clock(clock), .reset_0(reset_0), .flush(flush), .up_valid(up_valid),
    .up_data(up_data), .up_ready(up_ready4), .dn_valid(dn_valid4),
    .dn_data(dn_data4), .dn_ready(dn_ready), .stall_cnt(stall_cnt4)
  );

  always #5 clock = ~clock;

  // One clock edge; the model applies the FIFO rules to the inputs seen there.
  task automatic step();
    bit v, r, inc;
    v   = (q.size() > 0);
    r   = (q.size() < 2);
    inc = v && !dn_ready;
    @(posedge clock);
    if (!reset_0) begin
      q.delete();
      md   = '0;
      mc16 = 0;
      mc4  = 0;
    end else begin
      if (inc) begin
        mc16 = (mc16 < (1 << CW) - 1) ? mc16 + 1 : mc16;
        mc4  = (mc4 < (1 << CW4) - 1) ? mc4 + 1 : mc4;
      end
      if (flush) begin
        q.delete();
        md = '0;
      end else begin
        if (v && dn_ready) void'(q.pop_front());
        if (up_valid && r) q.push_back(up_data);
        if (q.size() > 0) md = q[0];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_0 = 1'b0; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    step(); step();
    n_checks++;
    if (dn_valid !== 1'b0 || dn_data !== '0 || up_ready !== 1'b1 || stall_cnt !== '0) begin
      n_errors++;
      $display("FAIL reset_values: got v=%b d=%h r=%b c=%0d want v=0 d=0 r=1 c=0",
               dn_valid, dn_data, up_ready, stall_cnt);
    end
    reset_0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dn_valid !== 1'b0 || dn_data !== '0 || up_ready !== 1'b1 || stall_cnt !== '0) begin
        n_errors++;
        $display("FAIL reset_idle cyc %0d: got v=%b d=%h r=%b c=%0d want v=0 d=0 r=1 c=0",
                 i, dn_valid, dn_data, up_ready, stall_cnt);
      end
    end
  endtask

  task automatic test_streaming();
    dn_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1;
      up_data  = PW'(i);
      step();
      n_checks++;
      if (dn_valid !== 1'b1 || dn_data !== PW'(i) || up_ready !== 1'b1 || dn_data !== md) begin
        n_errors++;
        $display("FAIL streaming item %0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, dn_valid, dn_data, up_ready, PW'(i));
      end
    end
    up_valid = 1'b0;
    step();
    n_checks++;
    if (dn_valid !== 1'b0 || up_ready !== 1'b1 || dn_data !== md) begin
      n_errors++;
      $display("FAIL streaming_drain: got v=%b r=%b d=%h want v=0 r=1 d=%h",
               dn_valid, up_ready, dn_data, md);
    end
  endtask

  task automatic test_back_pressure();
    int base;
    base = mc16;
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = PW'(8'hA); step();
    up_data = PW'(8'hB); step();
    n_checks++;
    if (up_ready !== 1'b0 || dn_valid !== 1'b1 || dn_data !== PW'(8'hA)) begin
      n_errors++;
      $display("FAIL bp_full: got r=%b v=%b d=%h want r=0 v=1 d=a", up_ready, dn_valid, dn_data);
    end
    up_data = PW'(8'hC);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (up_ready !== 1'b0 || dn_data !== PW'(8'hA) || q.size() != 2) begin
        n_errors++;
        $display("FAIL bp_hold cyc %0d: got r=%b d=%h want r=0 d=a", i, up_ready, dn_data);
      end
    end
    n_checks++;
    if (stall_cnt !== CW'(base + 4) || stall_cnt !== mc16[CW-1:0]) begin
      n_errors++;
      $display("FAIL bp_stall_cnt: got %0d want %0d", stall_cnt, base + 4);
    end
    dn_ready = 1'b1;
    step();
    n_checks++;
    if (dn_data !== PW'(8'hB) || dn_valid !== 1'b1 || up_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release_b: got d=%h v=%b r=%b want d=b v=1 r=1", dn_data, dn_valid, up_ready);
    end
    step();
    up_valid = 1'b0;
    n_checks++;
    if (dn_data !== PW'(8'hC) || dn_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release_c: got d=%h v=%b want d=c v=1", dn_data, dn_valid);
    end
    step();
    n_checks++;
    if (dn_valid !== 1'b0 || stall_cnt !== CW'(base + 4) || dn_data !== md) begin
      n_errors++;
      $display("FAIL bp_drain: got v=%b c=%0d want v=0 c=%0d", dn_valid, stall_cnt, base + 4);
    end
  endtask

  task automatic test_flush_full();
    int cnt_before;
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = PW'(8'h11); step();
    up_data = PW'(8'h22); step();
    cnt_before = mc16;
    flush = 1'b1; up_data = PW'(8'h33);
    step();
    flush = 1'b0;
    n_checks++;
    if (dn_valid !== 1'b0 || up_ready !== 1'b1 || dn_data !== '0 ||
        stall_cnt !== CW'(cnt_before + 1) || stall_cnt4 !== mc4[CW4-1:0]) begin
      n_errors++;
      $display("FAIL flush_full: got v=%b r=%b d=%h c=%0d want v=0 r=1 d=0 c=%0d",
               dn_valid, up_ready, dn_data, stall_cnt, cnt_before + 1);
    end
    up_valid = 1'b0; dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dn_valid !== 1'b0 || dn_data === PW'(8'h33) || stall_cnt !== mc16[CW-1:0]) begin
        n_errors++;
        $display("FAIL flush_after cyc %0d: got v=%b d=%h c=%0d want v=0 d=0 c=%0d",
                 i, dn_valid, dn_data, stall_cnt, mc16);
      end
    end
  endtask

  task automatic test_saturation();
    dn_ready = 1'b0; up_valid = 1'b1; up_data = PW'(8'h5A);
    step();
    up_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_checks++;
    if (stall_cnt4 !== 4'd15 || dn_valid4 !== 1'b1 || stall_cnt !== mc16[CW-1:0]) begin
      n_errors++;
      $display("FAIL sat_reach: got c4=%0d v4=%b c=%0d want c4=15 v4=1 c=%0d",
               stall_cnt4, dn_valid4, stall_cnt, mc16);
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== mc16[CW-1:0]) begin
      n_errors++;
      $display("FAIL sat_hold: got c4=%0d c=%0d want c4=15 c=%0d", stall_cnt4, stall_cnt, mc16);
    end
    dn_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    dn_ready = 1'b0; up_valid = 1'b1;
    up_data = PW'(8'h44); step();
    up_data = PW'(8'h55); step();
    reset_0 = 1'b0; flush = 1'b1; up_data = PW'(8'h66);
    step();
    n_checks++;
    if (dn_valid !== 1'b0 || dn_data !== '0 || up_ready !== 1'b1 || stall_cnt !== '0 ||
        stall_cnt4 !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: got v=%b d=%h r=%b c=%0d c4=%0d want v=0 d=0 r=1 c=0 c4=0",
               dn_valid, dn_data, up_ready, stall_cnt, stall_cnt4);
    end
    reset_0 = 1'b1; flush = 1'b0; dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_data = PW'(8'h70 + i);
      step();
      n_checks++;
      if (dn_valid !== 1'b1 || dn_data !== PW'(8'h70 + i) || up_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_mid_stream %0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                 i, dn_valid, dn_data, up_ready, PW'(8'h70 + i));
      end
    end
    up_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [95:0] rnd;
    for (int i = 0; i < 1500; i++) begin
      rnd      = {$urandom(), $urandom(), $urandom()};
      up_data  = rnd[PW-1:0];
      up_valid = ($urandom_range(0, 3) != 0);
      dn_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      reset_0  = ($urandom_range(0, 199) != 0);
      step();
      n_checks++;
      if (dn_valid !== (q.size() > 0) || up_ready !== (q.size() < 2) || dn_data !== md ||
          stall_cnt !== mc16[CW-1:0] || stall_cnt4 !== mc4[CW4-1:0] ||
          dn_valid4 !== (q.size() > 0) || up_ready4 !== (q.size() < 2) || dn_data4 !== md) begin
        n_errors++;
        $display("FAIL random cyc %0d: got v=%b r=%b d=%h c=%0d c4=%0d want v=%b r=%b d=%h c=%0d c4=%0d",
                 i, dn_valid, up_ready, dn_data, stall_cnt, stall_cnt4,
                 q.size() > 0, q.size() < 2, md, mc16, mc4);
      end
    end
    reset_0 = 1'b1; flush = 1'b0; up_valid = 1'b0;
  endtask

  initial begin
    q.delete();
    md = '0; mc16 = 0; mc4 = 0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush_full();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
